// File: rtl/mem_axi_lite_master_if.sv
// AXI4-Lite bus bundle between mem_axi_lite_master and its slave.
// Signal names keep the original m_* port names.
interface mem_axi_lite_master_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   logic [ADDR_W-1:0]   m_awaddr;
   logic                m_awvalid;
   logic                m_awready;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_wstrb;
   logic                m_wvalid;
   logic                m_wready;
   logic [1:0]          m_bresp;
   logic                m_bvalid;
   logic                m_bready;
   logic [ADDR_W-1:0]   m_araddr;
   logic                m_arvalid;
   logic                m_arready;
   logic [DATA_W-1:0]   m_rdata;
   logic [1:0]          m_rresp;
   logic                m_rvalid;
   logic                m_rready;

   modport master (
      output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
             m_araddr, m_arvalid, m_rready,
      input  m_awready, m_wready, m_bresp, m_bvalid, m_arready,
             m_rdata, m_rresp, m_rvalid
   );

   modport slave (
      input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
             m_araddr, m_arvalid, m_rready,
      output m_awready, m_wready, m_bresp, m_bvalid, m_arready,
             m_rdata, m_rresp, m_rvalid
   );
endinterface

// File: rtl/mem_axi_lite_master.sv
// Simple memory-request to AXI4-Lite master bridge, one transaction at a time.
// Requests are latched in IDLE; write has priority over read.
module mem_axi_lite_master #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            mem_ren,
   input  logic                            mem_wen,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   mem_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   mem_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] mem_wmask,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   mem_rdata,
   output logic                            mem_valid,
   output logic                            mem_err,
   mem_axi_lite_master_if.master           m_axi
);
   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      DONE
   } state_t;

   state_t                            state_q;
   state_t                            state_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]   wmask_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q;
   logic [1:0]                        resp_q;
   logic                              aw_done_q;
   logic                              w_done_q;
   logic                              aw_fire;
   logic                              w_fire;

   assign aw_fire = (state_q == WR_ADDR_DATA) && !aw_done_q && m_axi.m_awready;
   assign w_fire  = (state_q == WR_ADDR_DATA) && !w_done_q && m_axi.m_wready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (mem_wen)      state_d = WR_ADDR_DATA;
            else if (mem_ren) state_d = RD_ADDR;
         end
         WR_ADDR_DATA: begin
            if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_RESP;
         end
         WR_RESP: if (m_axi.m_bvalid)  state_d = DONE;
         RD_ADDR: if (m_axi.m_arready) state_d = RD_DATA;
         RD_DATA: if (m_axi.m_rvalid)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_axi.m_awvalid = 1'b0;
      m_axi.m_wvalid  = 1'b0;
      m_axi.m_bready  = 1'b0;
      m_axi.m_arvalid = 1'b0;
      m_axi.m_rready  = 1'b0;
      mem_valid       = 1'b0;
      unique case (state_q)
         WR_ADDR_DATA: begin
            m_axi.m_awvalid = !aw_done_q;
            m_axi.m_wvalid  = !w_done_q;
         end
         WR_RESP: m_axi.m_bready  = 1'b1;
         RD_ADDR: m_axi.m_arvalid = 1'b1;
         RD_DATA: m_axi.m_rready  = 1'b1;
         DONE:    mem_valid       = 1'b1;
         default: ;
      endcase
   end

   assign m_axi.m_awaddr = addr_q;
   assign m_axi.m_araddr = addr_q;
   assign m_axi.m_wdata  = wdata_q;
   assign m_axi.m_wstrb  = wmask_q;
   assign mem_rdata      = rdata_q;
   assign mem_err        = (state_q == DONE) && (resp_q != 2'b00);

   // Each write channel retires on its own handshake; both flags clear in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               aw_done_q <= 1'b0;
               w_done_q  <= 1'b0;
               if (mem_wen) begin
                  addr_q  <= mem_addr;
                  wdata_q <= mem_wdata;
                  wmask_q <= mem_wmask;
               end else if (mem_ren) begin
                  addr_q  <= mem_addr;
               end
            end
            WR_ADDR_DATA: begin
               if (aw_fire) aw_done_q <= 1'b1;
               if (w_fire)  w_done_q  <= 1'b1;
            end
            WR_RESP: if (m_axi.m_bvalid) resp_q <= m_axi.m_bresp;
            RD_DATA: begin
               if (m_axi.m_rvalid) begin
                  rdata_q <= m_axi.m_rdata;
                  resp_q  <= m_axi.m_rresp;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_axi_lite_master.sv
// Bench for mem_axi_lite_master: AXI-Lite slave model with memory, reference
// memory model feeding a scoreboard, and a channel stability monitor.
`timescale 1ns/1ps
module tb_mem_axi_lite_master;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_ren, mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [SW-1:0] mem_wmask;
   logic [DW-1:0] mem_rdata;
   logic          mem_valid, mem_err;

   always #5 clk = ~clk;

   mem_axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_axi_lite_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_err(mem_err),
      .m_axi(bus)
   );

   int errors = 0;
   int checks = 0;
   bit timed_out = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Memory contents: unwritten locations read back a fixed function of address.
   logic [63:0] ref_mem [logic [63:0]];
   logic [63:0] slv_mem [logic [63:0]];

   function automatic logic [63:0] dflt(logic [63:0] a);
      return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
   endfunction
   function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] d, logic [7:0] m);
      logic [63:0] bm = '0;
      for (int i = 0; i < 8; i++) if (m[i]) bm[i*8 +: 8] = 8'hFF;
      return (old & ~bm) | (d & bm);
   endfunction
   function automatic logic [63:0] ref_rd(logic [63:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction
   function automatic logic [63:0] slv_rd(logic [63:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
   endfunction
   function automatic bit err_region(logic [63:0] a);
      return a[15:12] == 4'hE;
   endfunction

   typedef struct {
      bit          is_rd;
      logic [63:0] rdata;
      bit          err;
   } exp_t;
   exp_t sb_q[$];

   // Expected AXI request for the transaction in flight.
   bit          cur_wr;
   logic [63:0] cur_addr, cur_wdata;
   logic [7:0]  cur_strb;
   int          aw_cnt, w_cnt, ar_cnt;
   logic [63:0] last_rd = '0;

   // Slave behaviour knobs.
   int p_rdy   = 100;
   int max_dly = 0;
   int w_block = 0;
   bit r_stall = 0;

   // Slave internal state.
   bit          aw_got, w_got, b_sched, b_fire, r_sched, r_fire;
   logic [63:0] aw_a, w_d, r_data_p;
   logic [7:0]  w_s;
   logic [1:0]  b_resp_p, r_resp_p;
   int          b_dly, r_dly;

   initial begin
      bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0;
      bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rresp = 0; bus.m_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
            bus.m_arready = 0; bus.m_rvalid = 0;
            aw_got = 0; w_got = 0; b_sched = 0; b_fire = 0; r_sched = 0; r_fire = 0;
            continue;
         end
         bus.m_awready = ($urandom_range(1, 100) <= p_rdy);
         if (bus.m_awvalid && bus.m_awready) begin
            aw_cnt++;
            chk("aw_on_write", cur_wr, 1);
            chk("awaddr", bus.m_awaddr, cur_addr);
            aw_got = 1; aw_a = bus.m_awaddr;
         end
         if (bus.m_wvalid && w_block > 0) begin
            bus.m_wready = 0; w_block--;
         end else bus.m_wready = ($urandom_range(1, 100) <= p_rdy);
         if (bus.m_wvalid && bus.m_wready) begin
            w_cnt++;
            chk("wdata", bus.m_wdata, cur_wdata);
            chk("wstrb", bus.m_wstrb, cur_strb);
            w_got = 1; w_d = bus.m_wdata; w_s = bus.m_wstrb;
         end
         if (aw_got && w_got) begin
            aw_got = 0; w_got = 0;
            slv_mem[aw_a] = merge(slv_rd(aw_a), w_d, w_s);
            b_resp_p = err_region(aw_a) ? 2'b10 : 2'b00;
            b_dly = $urandom_range(0, max_dly); b_sched = 1;
         end
         if (b_fire) begin bus.m_bvalid = 0; b_fire = 0; end
         if (b_sched && !bus.m_bvalid) begin
            if (b_dly == 0) begin bus.m_bvalid = 1; bus.m_bresp = b_resp_p; b_sched = 0; end
            else b_dly--;
         end
         if (bus.m_bvalid && bus.m_bready) b_fire = 1;
         if (!bus.m_bvalid) bus.m_bresp = 2'($urandom_range(0, 3));

         bus.m_arready = ($urandom_range(1, 100) <= p_rdy);
         if (bus.m_arvalid && bus.m_arready) begin
            ar_cnt++;
            chk("ar_on_read", cur_wr, 0);
            chk("araddr", bus.m_araddr, cur_addr);
            r_data_p = slv_rd(bus.m_araddr);
            r_resp_p = err_region(bus.m_araddr) ? 2'b10 : 2'b00;
            r_dly = $urandom_range(0, max_dly); r_sched = 1;
         end
         if (r_fire) begin bus.m_rvalid = 0; r_fire = 0; end
         if (r_sched && !bus.m_rvalid && !r_stall) begin
            if (r_dly == 0) begin
               bus.m_rvalid = 1; bus.m_rdata = r_data_p; bus.m_rresp = r_resp_p; r_sched = 0;
            end else r_dly--;
         end
         if (bus.m_rvalid && bus.m_rready) r_fire = 1;
         if (!bus.m_rvalid) begin
            bus.m_rdata = {$urandom, $urandom};
            bus.m_rresp = 2'($urandom_range(0, 3));
         end
      end
   end

   // Stability: a stalled VALID must stay high with unchanged payload.
   bit          s_aw, s_w, s_ar;
   logic [63:0] p_awaddr, p_wdata, p_araddr;
   logic [7:0]  p_wstrb;
   initial begin
      forever begin
         @(negedge clk); #2;
         if (rst) begin
            s_aw = 0; s_w = 0; s_ar = 0;
         end else begin
            if (s_aw) begin
               chk("awvalid_held", bus.m_awvalid, 1); chk("awaddr_stable", bus.m_awaddr, p_awaddr);
            end
            if (s_w) begin
               chk("wvalid_held", bus.m_wvalid, 1); chk("wdata_stable", bus.m_wdata, p_wdata);
               chk("wstrb_stable", bus.m_wstrb, p_wstrb);
            end
            if (s_ar) begin
               chk("arvalid_held", bus.m_arvalid, 1); chk("araddr_stable", bus.m_araddr, p_araddr);
            end
            if (bus.m_arvalid)
               chk("ar_exclusive", bus.m_awvalid || bus.m_wvalid || bus.m_bready, 0);
            s_aw = bus.m_awvalid && !bus.m_awready; p_awaddr = bus.m_awaddr;
            s_w  = bus.m_wvalid && !bus.m_wready;   p_wdata = bus.m_wdata; p_wstrb = bus.m_wstrb;
            s_ar = bus.m_arvalid && !bus.m_arready; p_araddr = bus.m_araddr;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (!rst && mem_valid) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_mem_valid: got mem_valid=1 expected no completion at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               chk("mem_err", mem_err, e.err);
               chk(e.is_rd ? "mem_rdata" : "mem_rdata_hold", mem_rdata, e.rdata);
            end
         end
      end
   end

   task automatic issue(bit wr, bit rd, logic [63:0] a, logic [63:0] d, logic [7:0] m);
      exp_t e;
      @(negedge clk);
      mem_wen = wr; mem_ren = rd; mem_addr = a; mem_wdata = d; mem_wmask = m;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      cur_wr = wr; cur_addr = a; cur_wdata = d; cur_strb = m;
      if (wr) begin
         ref_mem[a] = merge(ref_rd(a), d, m);
         e.is_rd = 0; e.rdata = last_rd;
      end else begin
         e.is_rd = 1; e.rdata = ref_rd(a); last_rd = e.rdata;
      end
      e.err = err_region(a);
      sb_q.push_back(e);
   endtask

   int lat, first_v, aw_hi, w_hi;
   task automatic wait_done();
      lat = 0; first_v = 0; aw_hi = 0; w_hi = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         lat++;
         if (first_v == 0 && (bus.m_awvalid || bus.m_wvalid || bus.m_arvalid)) first_v = lat;
         if (bus.m_awvalid) aw_hi++;
         if (bus.m_wvalid)  w_hi++;
         if (mem_valid) begin
            mem_wen = 0; mem_ren = 0;
            chk("aw_count", aw_cnt, cur_wr ? 1 : 0);
            chk("w_count",  w_cnt,  cur_wr ? 1 : 0);
            chk("ar_count", ar_cnt, cur_wr ? 0 : 1);
            return;
         end
         // Payload changes mid-transaction must be ignored.
         mem_addr = {$urandom, $urandom}; mem_wdata = {$urandom, $urandom};
         mem_wmask = 8'($urandom);
      end
      checks++; errors++; timed_out = 1;
      $display("FAIL op_timeout: got no mem_valid in 400 cycles expected one completion");
      mem_wen = 0; mem_ren = 0;
   endtask

   task automatic check_idle(string tag);
      chk({tag, "_awvalid"}, bus.m_awvalid, 0);
      chk({tag, "_wvalid"},  bus.m_wvalid, 0);
      chk({tag, "_bready"},  bus.m_bready, 0);
      chk({tag, "_arvalid"}, bus.m_arvalid, 0);
      chk({tag, "_rready"},  bus.m_rready, 0);
      chk({tag, "_mem_valid"}, mem_valid, 0);
      chk({tag, "_mem_err"}, mem_err, 0);
      chk({tag, "_mem_rdata"}, mem_rdata, 0);
      chk({tag, "_awaddr"}, bus.m_awaddr, 0);
   endtask

   initial begin
      logic [63:0] a;
      int          k;
      rst = 1; mem_ren = 0; mem_wen = 0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
      repeat (2) @(negedge clk);
      #1 check_idle("reset");
      @(negedge clk) rst = 0;

      // Read with immediate slave responses.
      slv_mem[64'h1000] = 64'hDEADBEEF_CAFEF00D;
      ref_mem[64'h1000] = 64'hDEADBEEF_CAFEF00D;
      issue(0, 1, 64'h1000, '0, '0);
      wait_done();
      chk("rd_first_valid_cycle", first_v, 1);
      chk("rd_latency", lat, 3);
      chk("rd_data_direct", mem_rdata, 64'hDEADBEEF_CAFEF00D);

      // Write with wready three cycles behind awready.
      w_block = 3;
      issue(1, 0, 64'h2008, 64'h11, 8'h0F);
      wait_done();
      chk("wr_awvalid_cycles", aw_hi, 1);
      chk("wr_wvalid_cycles", w_hi, 4);
      chk("wr_latency", lat, 6);
      issue(0, 1, 64'h2008, '0, '0);
      wait_done();

      // Simultaneous write and read request: write only.
      issue(1, 1, 64'h3000, 64'h0123_4567_89AB_CDEF, 8'hFF);
      wait_done();
      chk("both_latency", lat, 3);
      issue(0, 1, 64'h3000, '0, '0);
      wait_done();

      // SLVERR write then OKAY read.
      issue(1, 0, 64'hE010, 64'h5555_AAAA_5555_AAAA, 8'hF0);
      wait_done();
      issue(0, 1, 64'h1000, '0, '0);
      wait_done();

      // Reset while waiting for read data.
      r_stall = 1;
      issue(0, 1, 64'h1000, '0, '0);
      k = 0;
      while (!bus.m_rready && k < 50) begin @(negedge clk); k++; end
      chk("reached_rd_data", bus.m_rready, 1);
      @(negedge clk);
      rst = 1; mem_ren = 0;
      sb_q.delete();
      last_rd = '0;
      #1 check_idle("midreset");
      r_stall = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      issue(0, 1, 64'h2008, '0, '0);
      wait_done();
      chk("post_reset_rd_latency", lat, 3);

      // Randomized mixed traffic with backpressure.
      p_rdy = 60; max_dly = 3;
      for (int n = 0; n < 1000 && !timed_out; n++) begin
         k = $urandom_range(0, 2);
         a = (k == 0) ? 64'h1000 : (k == 1) ? 64'h2000 : 64'hE000;
         a = a + 64'($urandom_range(0, 7)) * 8;
         if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 7));
         if ($urandom_range(0, 3) == 0) a[63:32] = 32'h8000_0001;
         k = $urandom_range(0, 19);
         issue(k < 9 || k == 19, k >= 9, a, {$urandom, $urandom}, 8'($urandom));
         wait_done();
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_axi_lite_master.md
MEM_AXI_LITE_MASTER -- requirements
Module: mem_axi_lite_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64: width of the mem_addr, awaddr and araddr ports.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 64: data width; strobe width is C_M_AXI_DATA_WIDTH/8.
REQ-003 SHALL have ports:
  clk  in  1  sole clock, all state on rising edge
  rst  in  1  asynchronous, active-high reset
  mem_ren  in  1  read request (level)
  mem_wen  in  1  write request (level)
  mem_addr  in  ADDR  request address
  mem_wdata  in  DATA  write data
  mem_wmask  in  DATA/8  byte-enable mask
  mem_rdata  out  DATA  read data, valid with mem_valid
  mem_valid  out  1  one-cycle completion pulse
  mem_err  out  1  response was not OKAY, valid with mem_valid
  m_awaddr/m_awvalid  out  ADDR/1;  m_awready  in  1
  m_wdata/m_wstrb/m_wvalid  out  DATA/DATA8/1;  m_wready  in  1
  m_bresp  in  2;  m_bvalid  in  1;  m_bready  out  1
  m_araddr/m_arvalid  out  ADDR/1;  m_arready  in  1
  m_rdata  in  DATA;  m_rresp  in  2;  m_rvalid  in  1;  m_rready  out  1
REQ-004 SHALL use one clock (clk) and an asynchronous, active-high reset (rst).

Function
REQ-005 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-006 IDLE: mem_wen=1 -> latch addr/wdata/wmask, go WR_ADDR_DATA; else mem_ren=1 -> latch addr, go RD_ADDR; mem_wen and mem_ren both 1 -> write only, read discarded.
REQ-007 Request inputs SHALL be sampled only in IDLE; changes in other states ignored (latched copies drive AXI).
REQ-008 WR_ADDR_DATA: m_awvalid and m_wvalid asserted from the first cycle; each deasserts independently the cycle after its own handshake; go WR_RESP once both handshakes done (same or different cycles).
REQ-009 WR_RESP: m_bready=1; on m_bvalid capture m_bresp, go DONE.
REQ-010 RD_ADDR: m_arvalid=1 until m_arready, then RD_DATA.
REQ-011 RD_DATA: m_rready=1; on m_rvalid capture m_rdata and m_rresp, go DONE.
REQ-012 DONE: mem_valid=1 for exactly one cycle, mem_err=(captured resp != 2'b00), then IDLE; requester deasserts on mem_valid, a request still high in IDLE is a new transaction.
REQ-013 VALID signals SHALL not drop before handshake and SHALL not depend combinationally on READY; AXI payload stable while VALID high.
REQ-014 m_wstrb = latched mem_wmask; m_awaddr/m_araddr = latched mem_addr unmodified (no alignment).
REQ-015 mem_rdata SHALL hold the last captured read data until next read capture; write completion leaves it unchanged.
REQ-016 Minimum latency with READY/VALID responses immediate: read request cycle 0 -> arvalid cycle 1 -> rvalid handshake cycle 2 -> mem_valid cycle 3; write identical with aw/w in cycle 1, b in cycle 2.
REQ-017 At most one outstanding transaction; m_prot not driven (tied 3'b000 externally).

Reset
REQ-018 rst=1 SHALL immediately force IDLE, all VALID/READY outputs 0, mem_valid 0, mem_err 0, mem_rdata 0, latched regs 0.
REQ-019 Reset mid-transaction SHALL abandon it with no mem_valid; first request after rst release accepted normally.

Verification
REQ-020 Read, all slaves ready: mem_ren, addr 0x1000, rdata 0xDEADBEEF_CAFEF00D, rresp 0 -> arvalid cycle 1, mem_valid cycle 3, mem_rdata matches, mem_err 0.
REQ-021 Write, wready 3 cycles after awready: addr 0x2008, wdata 0x11, mask 0x0F -> awvalid drops after AW, wvalid held to its handshake, wstrb 0x0F, single mem_valid after bvalid.
REQ-022 Both mem_wen and mem_ren high -> only AW/W issued, no AR, one mem_valid.
REQ-023 bresp=2'b10 (SLVERR) -> mem_valid with mem_err=1; next read OKAY -> mem_err=0.
REQ-024 rst asserted in RD_DATA with rvalid low -> all outputs 0 at once, no mem_valid; new read after release completes.
REQ-025 Random READY/VALID backpressure, 1000 mixed ops -> VALID stability and payload match against reference memory model.
